ysyx_22040175_pipe_stage: RTL
=============================

# ysyx_22040175_pipe_stage

Parametrised elastic pipeline register that replaces the fixed-width, always-enabled if_id/id_ex/ex_mem/mem_wb registers of the five-stage core. It carries an opaque payload between two stages with a valid/ready handshake, backpressure, flush and an optional skid buffer for full throughput under a registered ready. It also keeps saturating stall and flush-drop counters for the performance monitors.

## Interface
Parameters:
- DATA_W, 128: payload width in bits (pc, inst, control fields packed by the instantiating stage); legal 1..512.
- SKID, 1: 1 = two-entry skid mode, in_ready registered; 0 = single-entry mode, in_ready combinational.
- CNT_W, 32: width of each performance counter; legal 8..64.

Ports:
- clk, input, 1: single clock, all state on rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_valid, input, 1: upstream payload valid.
- in_ready, output, 1: stage can accept this cycle.
- in_data, input, DATA_W: upstream payload.
- out_valid, output, 1: payload valid toward downstream.
- out_ready, input, 1: downstream accepts.
- out_data, output, DATA_W: payload toward downstream (main entry).
- flush, input, 1: discard all held entries (branch/jump redirect, ebreak).
- clr_cnt, input, 1: synchronous clear of both counters.
- stall_cnt, output, CNT_W: cycles with out_valid=1, out_ready=0, flush=0.
- drop_cnt, output, CNT_W: valid entries discarded by flush.

## Operation
- State: main entry (main_v, main_d); skid entry (skid_v, skid_d), present only when SKID=1.
- Accept event: in_valid && in_ready. Retire event: out_valid && out_ready.
- out_valid = main_v && !flush. out_data = main_d at all times, and is held stable while out_valid && !out_ready.
- SKID=1:
  - in_ready = !skid_v && !flush && !rst.
  - On retire, or when main is empty: main loads skid if skid_v, else in_data if accepting, else main_v becomes 0.
  - On accept with main occupied and not retiring: in_data goes to skid and skid_v becomes 1.
  - Skid drains into main on the next cycle that main is free.
  - Order is strictly FIFO. There is never a path from out_ready to in_ready.
- SKID=0:
  - in_ready = (!main_v || out_ready) && !flush && !rst.
  - Accept loads main. A retire without an accept clears main_v.
- Flush has priority over everything:
  - Next state is main_v = 0 and skid_v = 0.
  - No accept or retire happens in the flush cycle, because of the gating above.
  - drop_cnt += main_v + skid_v (0, 1 or 2) in the flush cycle.
  - Payload registers keep their old value; only the valids are cleared.
- Counters:
  - Each is unsigned and saturates at 2^CNT_W−1, never wrapping.
  - clr_cnt has priority over increment: the counter reads 0 the next cycle, and that cycle's event is lost.
  - Counting is independent of flush except as defined above.
- Reset (rst=1 at a clock edge), including in the middle of a transfer:
  - main_v = 0, skid_v = 0, main_d = 0, skid_d = 0, stall_cnt = 0, drop_cnt = 0.
  - While rst is high: out_valid = 0, in_ready = 0, out_data = 0.
  - One cycle after rst deasserts: in_ready = 1 in both modes.

## Timing
- Latency from in to out is one cycle: accepted at edge N, out_valid=1 during cycle N+1.
- Throughput is one transfer per cycle in both modes when out_ready is held at 1.
- SKID=1: in_ready falls one cycle after the first unretired accept that lands in skid. Upstream sees at most one extra accepted beat after out_ready drops.
- SKID=1: in_ready rises the cycle after skid drains.
- Simultaneous accept and retire with skid empty: main is replaced by in_data and skid stays empty.
- Simultaneous accept and retire with skid full cannot occur (in_ready=0).
- Flush asserted for k cycles: outputs stay gated for all k cycles; the stage is empty and accepting on the cycle after flush deasserts.

## Test plan
- Reset and streaming, SKID=1, DATA_W=128: rst for 2 cycles, then payloads 0x1..0x8 on consecutive cycles with out_ready=1 → during reset out_valid=0, out_data=0, in_ready=0; afterwards out_data 0x1..0x8 one cycle delayed, no bubbles, stall_cnt=0.
- Backpressure, SKID=1: stream 0xA,0xB,0xC,…; drop out_ready for 3 cycles after 0xA appears → 0xA held stable; 0xB goes to skid; in_ready=0 for the rest of the stall; no beat lost or duplicated; stall_cnt=3.
- Flush with both entries full: after the backpressure case, assert flush for 1 cycle with in_valid=1 → out_valid=0 and in_ready=0 that cycle; drop_cnt=2; next cycle the stage is empty and in_ready=1.
- SKID=0 comb ready: main full, out_ready=1, in_valid=1 with 0x55 → in_ready=1 in the same cycle; 0x55 appears next cycle; with out_ready=0, in_ready=0.
- Saturation and clear, CNT_W=8: hold out_valid=1, out_ready=0 for 300 cycles → stall_cnt=255 with no wrap; pulse clr_cnt → stall_cnt=0 the next cycle.
- Mid-transfer reset: rst in the cycle right after a skid fill → all valids 0; the payload is not replayed after release.

Source files
------------

// File: rtl/ysyx_22040175_pipe_stage.sv
// Elastic pipeline register between two core stages: valid/ready handshake, flush,
// optional two-entry skid buffer, and saturating stall / flush-drop counters.
module ysyx_22040175_pipe_stage #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam bit          UseSkid = (SKID != 0);
  localparam int unsigned SumW    = CNT_W + 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

  logic              accept;
  logic              retire;
  logic              stall_inc;
  logic [1:0]        drop_inc;
  logic [SumW-1:0]   stall_sum;
  logic [SumW-1:0]   drop_sum;

  // In skid mode in_ready depends only on registered state, never on out_ready.
  always_comb begin
    if (UseSkid) begin
      in_ready = !skid_v_q && !flush && !rst;
    end else begin
      in_ready = (!main_v_q || out_ready) && !flush && !rst;
    end
    out_valid = main_v_q && !flush && !rst;
    out_data  = rst ? '0 : main_data_q;
    accept    = in_valid && in_ready;
    retire    = out_valid && out_ready;
  end

  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;

    if (flush) begin
      // Payload registers keep their contents; only the valids drop.
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (UseSkid) begin
      if (retire || !main_v_q) begin
        if (skid_v_q) begin
          main_data_d = skid_data_q;
          main_v_d    = 1'b1;
          skid_v_d    = 1'b0;
        end else if (accept) begin
          main_data_d = in_data;
          main_v_d    = 1'b1;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (accept) begin
        skid_data_d = in_data;
        skid_v_d    = 1'b1;
      end
    end else begin
      if (accept) begin
        main_data_d = in_data;
        main_v_d    = 1'b1;
      end else if (retire) begin
        main_v_d = 1'b0;
      end
    end
  end

  // Saturating counters: the extra sum bit flags an overflow past CntMax.
  always_comb begin
    stall_inc = out_valid && !out_ready;
    drop_inc  = flush ? ({1'b0, main_v_q} + {1'b0, skid_v_q}) : 2'd0;
    stall_sum = {1'b0, stall_cnt_q} + SumW'(stall_inc);
    drop_sum  = {1'b0, drop_cnt_q} + SumW'(drop_inc);

    stall_cnt_d = stall_sum[CNT_W] ? CntMax : stall_sum[CNT_W-1:0];
    drop_cnt_d  = drop_sum[CNT_W] ? CntMax : drop_sum[CNT_W-1:0];
    if (clr_cnt) begin
      stall_cnt_d = '0;
      drop_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      skid_data_q <= '0;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
